// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants, instruction field layout and select type
//               for the operand-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int P_WIDTH = 16;
    localparam int P_NREGS = 8;
    localparam int P_OPW   = 5;
    localparam int P_AW    = $clog2(P_NREGS);
    localparam int P_SELW  = 2;

    // Instruction layout: {sel, rs2, rs1, rd, op} from MSB to LSB
    localparam int OP_LSB  = 0;
    localparam int RD_LSB  = 5;
    localparam int RS1_LSB = 8;
    localparam int RS2_LSB = 11;
    localparam int SEL_LSB = 14;

    // Encoding follows the input order of the downstream word selector
    typedef enum logic [P_SELW-1:0] {
        SEL_W0 = 2'd0,
        SEL_W1 = 2'd1,
        SEL_W2 = 2'd2,
        SEL_W3 = 2'd3
    } sel_t;

endpackage

`default_nettype wire

// File: rtl/regfile.sv
// ============================================================================
// Module      : regfile
// Description : Register file, two combinational read ports, one synchronous
//               write port. R0 reads as zero and ignores writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile #(
    parameter int P_WIDTH = cpu_pkg::P_WIDTH,
    parameter int P_NREGS = cpu_pkg::P_NREGS,
    parameter int P_AW    = $clog2(P_NREGS)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_we,
    input  logic [P_AW-1:0]    i_waddr,
    input  logic [P_WIDTH-1:0] i_wdata,
    input  logic [P_AW-1:0]    i_raddr_a,
    output logic [P_WIDTH-1:0] o_rdata_a,
    input  logic [P_AW-1:0]    i_raddr_b,
    output logic [P_WIDTH-1:0] o_rdata_b
);

    logic [P_WIDTH-1:0] r_mem [0:P_NREGS-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < P_NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_mem[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_mem[i_raddr_b];

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// Module      : operand_fetch
// Description : Decode/operand-fetch pipeline stage with write-back bypass at
//               capture and write-back forwarding into a stalled bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch
    import cpu_pkg::*;
#(
    parameter int P_WIDTH = cpu_pkg::P_WIDTH,
    parameter int P_NREGS = cpu_pkg::P_NREGS,
    parameter int P_OPW   = cpu_pkg::P_OPW
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [15:0]        i_instr,
    input  logic               i_wb_en,
    input  logic [2:0]         i_wb_addr,
    input  logic [P_WIDTH-1:0] i_wb_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [P_OPW-1:0]   o_op,
    output logic [2:0]         o_rd,
    output logic [1:0]         o_sel,
    output logic [P_WIDTH-1:0] o_a,
    output logic [P_WIDTH-1:0] o_b
);

    localparam int c_AW = $clog2(P_NREGS);

    logic               r_valid;
    logic [P_OPW-1:0]   r_op;
    logic [c_AW-1:0]    r_rd;
    sel_t               r_sel;
    logic [c_AW-1:0]    r_rs1;
    logic [c_AW-1:0]    r_rs2;
    logic [P_WIDTH-1:0] r_a;
    logic [P_WIDTH-1:0] r_b;

    logic [P_OPW-1:0]   w_op;
    logic [c_AW-1:0]    w_rd;
    logic [c_AW-1:0]    w_rs1;
    logic [c_AW-1:0]    w_rs2;
    sel_t               w_sel;
    logic [P_WIDTH-1:0] w_rf_a;
    logic [P_WIDTH-1:0] w_rf_b;
    logic [P_WIDTH-1:0] w_cap_a;
    logic [P_WIDTH-1:0] w_cap_b;
    logic               w_accept;
    logic               w_hold;
    logic               w_hfwd_a;
    logic               w_hfwd_b;

    assign w_op  = i_instr[OP_LSB  +: P_OPW];
    assign w_rd  = i_instr[RD_LSB  +: c_AW];
    assign w_rs1 = i_instr[RS1_LSB +: c_AW];
    assign w_rs2 = i_instr[RS2_LSB +: c_AW];
    assign w_sel = sel_t'(i_instr[SEL_LSB +: P_SELW]);

    regfile #(
        .P_WIDTH (P_WIDTH),
        .P_NREGS (P_NREGS),
        .P_AW    (c_AW)
    ) u_regfile (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_we      (i_wb_en),
        .i_waddr   (i_wb_addr),
        .i_wdata   (i_wb_data),
        .i_raddr_a (w_rs1),
        .o_rdata_a (w_rf_a),
        .i_raddr_b (w_rs2),
        .o_rdata_b (w_rf_b)
    );

    assign o_ready  = !r_valid || i_ready;
    assign w_accept = i_valid && o_ready;
    assign w_hold   = r_valid && !i_ready;

    // The register file has no internal bypass, so a same-cycle write is
    // picked up here instead of reading the stale entry.
    assign w_cap_a = (i_wb_en && (i_wb_addr == w_rs1) && (w_rs1 != '0)) ? i_wb_data : w_rf_a;
    assign w_cap_b = (i_wb_en && (i_wb_addr == w_rs2) && (w_rs2 != '0)) ? i_wb_data : w_rf_b;

    assign w_hfwd_a = w_hold && i_wb_en && (i_wb_addr == r_rs1) && (r_rs1 != '0);
    assign w_hfwd_b = w_hold && i_wb_en && (i_wb_addr == r_rs2) && (r_rs2 != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_op    <= '0;
            r_rd    <= '0;
            r_sel   <= SEL_W0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_valid <= w_accept || w_hold;
            if (w_accept) begin
                r_op  <= w_op;
                r_rd  <= w_rd;
                r_sel <= w_sel;
                r_rs1 <= w_rs1;
                r_rs2 <= w_rs2;
                r_a   <= w_cap_a;
                r_b   <= w_cap_b;
            end else begin
                if (w_hfwd_a) begin
                    r_a <= i_wb_data;
                end
                if (w_hfwd_b) begin
                    r_b <= i_wb_data;
                end
            end
        end
    end

    assign o_valid = r_valid;
    assign o_op    = r_op;
    assign o_rd    = r_rd;
    assign o_sel   = r_sel;
    assign o_a     = r_a;
    assign o_b     = r_b;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// Module      : tb_operand_fetch
// Description : Self-checking bench for operand_fetch: directed vector table,
//               scoreboard-checked random and streaming sequences, reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [15:0] i_instr = '0;
    logic        i_wb_en = 1'b0;
    logic [2:0]  i_wb_addr = '0;
    logic [15:0] i_wb_data = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [4:0]  o_op;
    logic [2:0]  o_rd;
    logic [1:0]  o_sel;
    logic [15:0] o_a;
    logic [15:0] o_b;

    int n_checks = 0;
    int n_errors = 0;

    operand_fetch dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_instr   (i_instr),
        .i_wb_en   (i_wb_en),
        .i_wb_addr (i_wb_addr),
        .i_wb_data (i_wb_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_op      (o_op),
        .o_rd      (o_rd),
        .o_sel     (o_sel),
        .o_a       (o_a),
        .o_b       (o_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] instr;
        logic        rdy;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        e_rdy;
        logic        e_v;
        logic [4:0]  e_op;
        logic [2:0]  e_rd;
        logic [1:0]  e_sel;
        logic [15:0] e_a;
        logic [15:0] e_b;
    } vec_t;

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [15:0] a;
        logic [15:0] b;
    } bundle_t;

    // Reference model: architectural register contents and in-flight bundles
    logic [15:0] m_rf [0:7];
    bundle_t     m_q [$];

    function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic [1:0] sel);
        return {sel, rs2, rs1, rd, op};
    endfunction

    function automatic vec_t mkv(input logic v, input logic [15:0] instr, input logic rdy,
                                 input logic we, input logic [2:0] wa, input logic [15:0] wd,
                                 input logic e_rdy, input logic e_v, input logic [4:0] e_op,
                                 input logic [2:0] e_rd, input logic [1:0] e_sel,
                                 input logic [15:0] e_a, input logic [15:0] e_b);
        vec_t t;
        t.v = v; t.instr = instr; t.rdy = rdy; t.we = we; t.wa = wa; t.wd = wd;
        t.e_rdy = e_rdy; t.e_v = e_v; t.e_op = e_op; t.e_rd = e_rd; t.e_sel = e_sel;
        t.e_a = e_a; t.e_b = e_b;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_q.delete();
    endtask

    task automatic drive(input logic v, input logic [15:0] ins, input logic rdy,
                         input logic we, input logic [2:0] wa, input logic [15:0] wd);
        i_valid = v; i_instr = ins; i_ready = rdy;
        i_wb_en = we; i_wb_addr = wa; i_wb_data = wd;
    endtask

    // One cycle checked against the scoreboard, then the model advances
    task automatic step(input logic v, input logic [15:0] ins, input logic rdy,
                        input logic we, input logic [2:0] wa, input logic [15:0] wd);
        bundle_t nb;
        bundle_t hd;
        logic    acc;
        @(negedge clk);
        drive(v, ins, rdy, we, wa, wd);
        #1;
        chk("ready", {31'd0, o_ready}, {31'd0, (m_q.size() == 0) || rdy});
        chk("valid", {31'd0, o_valid}, {31'd0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            hd = m_q[0];
            chk("op",  {27'd0, o_op},  {27'd0, hd.op});
            chk("rd",  {29'd0, o_rd},  {29'd0, hd.rd});
            chk("sel", {30'd0, o_sel}, {30'd0, hd.sel});
            chk("a",   {16'd0, o_a},   {16'd0, hd.a});
            chk("b",   {16'd0, o_b},   {16'd0, hd.b});
        end
        acc = v && ((m_q.size() == 0) || rdy);
        if (m_q.size() != 0 && !rdy && we) begin
            hd = m_q[0];
            if (wa != 3'd0 && wa == hd.rs1) hd.a = wd;
            if (wa != 3'd0 && wa == hd.rs2) hd.b = wd;
            m_q[0] = hd;
        end
        if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
        if (acc) begin
            nb.op  = ins[4:0];
            nb.rd  = ins[7:5];
            nb.rs1 = ins[10:8];
            nb.rs2 = ins[13:11];
            nb.sel = ins[15:14];
            nb.a   = (nb.rs1 == 3'd0) ? 16'd0 : (we && wa == nb.rs1) ? wd : m_rf[nb.rs1];
            nb.b   = (nb.rs2 == 3'd0) ? 16'd0 : (we && wa == nb.rs2) ? wd : m_rf[nb.rs2];
            m_q.push_back(nb);
        end
        if (we && wa != 3'd0) m_rf[wa] = wd;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
        chk({tag, "_op"},    {27'd0, o_op},    32'd0);
        chk({tag, "_rd"},    {29'd0, o_rd},    32'd0);
        chk({tag, "_sel"},   {30'd0, o_sel},   32'd0);
        chk({tag, "_a"},     {16'd0, o_a},     32'd0);
        chk({tag, "_b"},     {16'd0, o_b},     32'd0);
    endtask

    vec_t tbl [13];

    initial begin
        tbl[0]  = mkv(0, 16'h0, 1, 1, 3'd3, 16'h1234, 1, 0, 5'h00, 3'd0, 2'd0, 16'h0000, 16'h0000);
        tbl[1]  = mkv(0, 16'h0, 1, 1, 3'd5, 16'hABCD, 1, 0, 5'h00, 3'd0, 2'd0, 16'h0000, 16'h0000);
        tbl[2]  = mkv(1, mk(5'h0A, 3'd1, 3'd3, 3'd5, 2'd2), 1, 0, 3'd0, 16'h0,
                      1, 1, 5'h0A, 3'd1, 2'd2, 16'h1234, 16'hABCD);
        tbl[3]  = mkv(1, mk(5'h11, 3'd2, 3'd4, 3'd4, 2'd3), 1, 1, 3'd4, 16'h00FF,
                      1, 1, 5'h11, 3'd2, 2'd3, 16'h00FF, 16'h00FF);
        tbl[4]  = mkv(0, 16'h0, 1, 1, 3'd0, 16'hFFFF, 1, 0, 5'h11, 3'd2, 2'd3, 16'h00FF, 16'h00FF);
        tbl[5]  = mkv(0, 16'h0, 1, 1, 3'd6, 16'h0001, 1, 0, 5'h11, 3'd2, 2'd3, 16'h00FF, 16'h00FF);
        tbl[6]  = mkv(1, mk(5'h03, 3'd7, 3'd0, 3'd6, 2'd1), 1, 0, 3'd0, 16'h0,
                      1, 1, 5'h03, 3'd7, 2'd1, 16'h0000, 16'h0001);
        tbl[7]  = mkv(0, 16'h0, 0, 1, 3'd6, 16'h7777, 0, 1, 5'h03, 3'd7, 2'd1, 16'h0000, 16'h7777);
        tbl[8]  = mkv(1, mk(5'h15, 3'd4, 3'd2, 3'd2, 2'd0), 0, 1, 3'd0, 16'h5555,
                      0, 1, 5'h03, 3'd7, 2'd1, 16'h0000, 16'h7777);
        tbl[9]  = mkv(0, 16'h0, 1, 0, 3'd0, 16'h0, 1, 0, 5'h03, 3'd7, 2'd1, 16'h0000, 16'h7777);
        tbl[10] = mkv(1, mk(5'h1F, 3'd5, 3'd6, 3'd3, 2'd0), 1, 0, 3'd0, 16'h0,
                      1, 1, 5'h1F, 3'd5, 2'd0, 16'h7777, 16'h1234);
        tbl[11] = mkv(1, mk(5'h02, 3'd1, 3'd1, 3'd1, 2'd1), 0, 1, 3'd2, 16'hBEEF,
                      0, 1, 5'h1F, 3'd5, 2'd0, 16'h7777, 16'h1234);
        tbl[12] = mkv(0, 16'h0, 1, 0, 3'd0, 16'h0, 1, 0, 5'h1F, 3'd5, 2'd0, 16'h7777, 16'h1234);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: fetch, capture bypass, R0 rules, hold forwarding
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].instr, tbl[i].rdy, tbl[i].we, tbl[i].wa, tbl[i].wd);
            #1;
            chk($sformatf("v%0d_ready", i), {31'd0, o_ready}, {31'd0, tbl[i].e_rdy});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {31'd0, o_valid}, {31'd0, tbl[i].e_v});
            chk($sformatf("v%0d_op", i),    {27'd0, o_op},    {27'd0, tbl[i].e_op});
            chk($sformatf("v%0d_rd", i),    {29'd0, o_rd},    {29'd0, tbl[i].e_rd});
            chk($sformatf("v%0d_sel", i),   {30'd0, o_sel},   {30'd0, tbl[i].e_sel});
            chk($sformatf("v%0d_a", i),     {16'd0, o_a},     {16'd0, tbl[i].e_a});
            chk($sformatf("v%0d_b", i),     {16'd0, o_b},     {16'd0, tbl[i].e_b});
        end

        // Fresh start for the scoreboard-driven phases
        @(negedge clk);
        drive(0, 16'h0, 0, 0, 3'd0, 16'h0);
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back streaming, then i_ready toggling with continuous input
        for (int i = 0; i < 4; i++)
            step(1, mk(5'(i + 1), 3'(i), 3'd0, 3'd0, 2'(i)), 1, 0, 3'd0, 16'h0);
        for (int i = 0; i < 8; i++)
            step(1, mk(5'(i + 8), 3'(i), 3'd0, 3'd0, 2'(i)), (i % 2) == 0, 0, 3'd0, 16'h0);
        for (int i = 0; i < 3; i++)
            step(0, 16'h0, 1, 0, 3'd0, 16'h0);

        // Randomized traffic with write-back activity
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 16'($urandom));
        end

        // Mid-stream asynchronous reset with a held bundle
        step(1, mk(5'h1B, 3'd6, 3'd1, 3'd2, 2'd3), 0, 0, 3'd0, 16'h0);
        step(1, mk(5'h1C, 3'd6, 3'd1, 3'd2, 2'd3), 0, 0, 3'd0, 16'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("async_reset");
        chk("async_reset_ready", {31'd0, o_ready}, 32'd1);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        drive(0, 16'h0, 1, 0, 3'd0, 16'h0);
        rst_n = 1'b1;

        // Every register reads zero after reset
        for (int r = 1; r < 8; r++)
            step(1, mk(5'(r), 3'(r), 3'(r), 3'(r), 2'd0), 1, 0, 3'd0, 16'h0);
        step(0, 16'h0, 1, 0, 3'd0, 16'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
